// File: rtl/l2_mem_request_ctrl.sv
// L2 miss handler: optional victim writeback, then line refill, with a per-command wait timeout.
// Commands and response are registered; one miss in flight, req_ready only while idle.
module l2_mem_request_ctrl #(
  parameter int TNUM    = 22,
  parameter int INUM    = 26 - TNUM,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TNUM-1:0]   req_tag,
  input  logic [INUM-1:0]   req_index,
  input  logic              req_dirty,
  input  logic [TNUM-1:0]   req_victim_tag,
  input  logic [511:0]      req_victim_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [511:0]      resp_data,
  output logic              resp_err,
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [TNUM-1:0]   tag_L2_MEM,
  output logic [INUM-1:0]   index_L2_MEM,
  output logic [TNUM-1:0]   write_tag_L2_MEM,
  output logic [511:0]      write_data_L2_MEM,
  input  logic              ready_MEM_L2,
  input  logic [511:0]      read_data_MEM_L2
);

  typedef enum logic [2:0] {IDLE, WB, GAP, FILL, RESP} state_t;

  // Last wait cycle: the command is dropped when the counter would reach TIMEOUT.
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

  state_t          state;
  logic [9:0]      wait_cnt;
  logic [TNUM-1:0] tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      tag_q             <= '0;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_data         <= '0;
      resp_err          <= 1'b0;
      read_L2_MEM       <= 1'b0;
      write_L2_MEM      <= 1'b0;
      tag_L2_MEM        <= '0;
      index_L2_MEM      <= '0;
      write_tag_L2_MEM  <= '0;
      write_data_L2_MEM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tag_q        <= req_tag;
            index_L2_MEM <= req_index;
            wait_cnt     <= '0;
            req_ready    <= 1'b0;
            if (req_dirty) begin
              state             <= WB;
              write_L2_MEM      <= 1'b1;
              write_tag_L2_MEM  <= req_victim_tag;
              write_data_L2_MEM <= req_victim_data;
            end else begin
              state       <= FILL;
              read_L2_MEM <= 1'b1;
              tag_L2_MEM  <= req_tag;
            end
          end
        end
        WB: begin
          if (ready_MEM_L2) begin
            state        <= GAP;
            write_L2_MEM <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= RESP;
            write_L2_MEM <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_data    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        GAP: begin
          state       <= FILL;
          read_L2_MEM <= 1'b1;
          tag_L2_MEM  <= tag_q;
          wait_cnt    <= '0;
        end
        FILL: begin
          // Ready wins over a coincident timeout.
          if (ready_MEM_L2) begin
            state       <= RESP;
            read_L2_MEM <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b0;
            resp_data   <= read_data_MEM_L2;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= RESP;
            read_L2_MEM <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            resp_data   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_request_ctrl.sv
// Bench for l2_mem_request_ctrl: transaction-level model predicts command lengths, gap and response.
module tb_l2_mem_request_ctrl;
  localparam int TNUM = 22;
  localparam int INUM = 4;
  localparam int TIMEOUT = 1023;
  localparam int NEVER = 100000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [TNUM-1:0]   req_tag = '0;
  logic [INUM-1:0]   req_index = '0;
  logic              req_dirty = 1'b0;
  logic [TNUM-1:0]   req_victim_tag = '0;
  logic [511:0]      req_victim_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [511:0]      resp_data;
  logic              resp_err;
  logic              read_L2_MEM;
  logic              write_L2_MEM;
  logic [TNUM-1:0]   tag_L2_MEM;
  logic [INUM-1:0]   index_L2_MEM;
  logic [TNUM-1:0]   write_tag_L2_MEM;
  logic [511:0]      write_data_L2_MEM;
  logic              ready_MEM_L2 = 1'b0;
  logic [511:0]      read_data_MEM_L2 = '0;

  int n_tests = 0;
  int n_fail = 0;

  l2_mem_request_ctrl #(.TNUM(TNUM), .INUM(INUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_index(req_index),
    .req_dirty(req_dirty), .req_victim_tag(req_victim_tag), .req_victim_data(req_victim_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM), .tag_L2_MEM(tag_L2_MEM),
    .index_L2_MEM(index_L2_MEM), .write_tag_L2_MEM(write_tag_L2_MEM),
    .write_data_L2_MEM(write_data_L2_MEM), .ready_MEM_L2(ready_MEM_L2),
    .read_data_MEM_L2(read_data_MEM_L2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Plays the memory side and checks one miss end to end against the model.
  task automatic run_txn(input logic [TNUM-1:0] tag, input logic [INUM-1:0] idx, input bit dirty,
                         input logic [TNUM-1:0] vtag, input logic [511:0] vdata,
                         input int wdelay, input int rdelay, input logic [511:0] rdata, input int bp);
    int w_exp, r_exp, g_exp;
    bit wb_to, rd_to, err_exp;
    logic [511:0] data_exp;
    int wcyc, rcyc, gcyc, ovl, fbad, bpbad, cyc;
    bit done;
    wb_to    = dirty && (wdelay > TIMEOUT);
    w_exp    = !dirty ? 0 : (wb_to ? TIMEOUT : wdelay);
    g_exp    = (dirty && !wb_to) ? 1 : 0;
    rd_to    = !wb_to && (rdelay > TIMEOUT);
    r_exp    = wb_to ? 0 : (rd_to ? TIMEOUT : rdelay);
    err_exp  = wb_to || rd_to;
    data_exp = err_exp ? '0 : rdata;
    wcyc = 0; rcyc = 0; gcyc = 0; ovl = 0; fbad = 0; bpbad = 0; cyc = 0; done = 0;

    chk("idle_ready", 512'(req_ready), 512'(1));
    req_valid = 1'b1; req_tag = tag; req_index = idx; req_dirty = dirty;
    req_victim_tag = vtag; req_victim_data = vdata;
    @(negedge clk);
    req_valid = 1'b0; req_tag = '0; req_victim_data = rnd512();
    while (!done && cyc < 3*TIMEOUT + 64) begin
      cyc++;
      ready_MEM_L2 = 1'b0;
      read_data_MEM_L2 = rnd512();
      if (resp_valid) done = 1;
      else begin
        if (write_L2_MEM && read_L2_MEM) ovl++;
        if (write_L2_MEM) begin
          wcyc++;
          if (write_tag_L2_MEM !== vtag || index_L2_MEM !== idx || write_data_L2_MEM !== vdata) fbad++;
          if (wcyc == wdelay) ready_MEM_L2 = 1'b1;
        end else if (read_L2_MEM) begin
          rcyc++;
          if (tag_L2_MEM !== tag || index_L2_MEM !== idx) fbad++;
          if (rcyc == rdelay) begin
            ready_MEM_L2 = 1'b1;
            read_data_MEM_L2 = rdata;
          end
        end else begin
          gcyc++;
          ready_MEM_L2 = 1'b1;  // stray pulse in the gap must not matter
        end
        @(negedge clk);
      end
    end
    ready_MEM_L2 = 1'b0;
    chk("resp_seen", 512'(resp_valid), 512'(1));
    if (!done) return;
    chk("write_cycles", 512'(wcyc), 512'(w_exp));
    chk("gap_cycles", 512'(gcyc), 512'(g_exp));
    chk("read_cycles", 512'(rcyc), 512'(r_exp));
    chk("cmd_overlap", 512'(ovl), 512'(0));
    chk("cmd_fields", 512'(fbad), 512'(0));
    chk("resp_err", 512'(resp_err), 512'(err_exp));
    chk("resp_data", resp_data, data_exp);
    chk("index_hold", 512'(index_L2_MEM), 512'(idx));
    chk("resp_req_ready", 512'(req_ready), 512'(0));
    for (int i = 0; i < bp; i++) begin
      ready_MEM_L2 = (i == 2);
      read_data_MEM_L2 = rnd512();
      if (!resp_valid || resp_data !== data_exp || resp_err !== err_exp || req_ready ||
          read_L2_MEM || write_L2_MEM) bpbad++;
      @(negedge clk);
    end
    ready_MEM_L2 = 1'b0;
    chk("bp_stable", 512'(bpbad), 512'(0));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle", 512'(req_ready), 512'(1));
    chk("resp_drop", 512'(resp_valid), 512'(0));
  endtask

  initial begin
    logic [511:0] vdata;
    logic [511:0] a5;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 512'(req_ready), 512'(1));
    chk("rst_resp_valid", 512'(resp_valid), 512'(0));
    chk("rst_cmds", 512'({read_L2_MEM, write_L2_MEM}), 512'(0));
    chk("rst_resp", 512'({resp_err, resp_data}), 512'(0));
    chk("rst_addr", 512'({tag_L2_MEM, index_L2_MEM, write_tag_L2_MEM}), 512'(0));
    rst = 1'b0;

    // Stray ready while idle.
    ready_MEM_L2 = 1'b1; read_data_MEM_L2 = rnd512();
    @(negedge clk);
    ready_MEM_L2 = 1'b0;
    chk("idle_pulse_ready", 512'(req_ready), 512'(1));
    chk("idle_pulse_state", 512'({resp_valid, read_L2_MEM, write_L2_MEM}), 512'(0));
    chk("idle_pulse_data", resp_data, 512'(0));

    for (int i = 0; i < 64; i++) a5[8*i +: 8] = 8'hA5;
    run_txn(22'h000123, 4'd5, 1'b0, '0, '0, NEVER, 64, a5, 0);

    for (int i = 0; i < 16; i++) vdata[32*i +: 32] = i;
    run_txn(22'h02ABCD, 4'd9, 1'b1, 22'h3FFFFF, vdata, 17, 30, rnd512(), 0);

    run_txn(22'h001234, 4'd2, 1'b0, '0, '0, NEVER, 12, rnd512(), 10);

    run_txn(22'h00BEEF, 4'd7, 1'b0, '0, '0, NEVER, NEVER, rnd512(), 2);
    run_txn(22'h00CAFE, 4'd1, 1'b1, 22'h155555, rnd512(), NEVER, 5, rnd512(), 0);
    run_txn(22'h000777, 4'd3, 1'b0, '0, '0, NEVER, TIMEOUT, rnd512(), 0);
    run_txn(22'h000888, 4'd4, 1'b1, 22'h2AAAAA, rnd512(), TIMEOUT, 3, rnd512(), 0);

    for (int t = 0; t < 10; t++)
      run_txn(22'($urandom), 4'($urandom), 1'($urandom), 22'($urandom), rnd512(),
              $urandom_range(1, 80), $urandom_range(1, 80), rnd512(), $urandom_range(0, 5));

    // Reset while the refill is outstanding.
    req_valid = 1'b1; req_tag = 22'h0ABCDE; req_index = 4'd6; req_dirty = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_read", 512'(read_L2_MEM), 512'(1));
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmds", 512'({read_L2_MEM, write_L2_MEM}), 512'(0));
    chk("mid_rst_ready", 512'(req_ready), 512'(1));
    chk("mid_rst_resp", 512'({resp_valid, resp_err, resp_data}), 512'(0));
    rst = 1'b0;
    run_txn(22'h012345, 4'd8, 1'b1, 22'h001111, rnd512(), 9, 11, rnd512(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_mem_request_ctrl.md
L2_MEM_REQUEST_CTRL -- requirements
Module: l2_mem_request_ctrl

Interface
REQ-001 The block SHALL have parameter TNUM, default 22, meaning tag width.
REQ-002 The block SHALL have parameter INUM, default 26-TNUM, meaning index width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles to wait for ready_MEM_L2 per command.
REQ-004 The block SHALL have ports:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-high reset
 req_valid  in  1  L2 miss request
 req_ready  out  1  block idle and accepting a request
 req_tag  in  TNUM  miss-line tag
 req_index  in  INUM  miss-line index
 req_dirty  in  1  victim line needs writeback
 req_victim_tag  in  TNUM  victim tag
 req_victim_data  in  512  victim line
 resp_valid  out  1  refill line available
 resp_ready  in  1  L2 consumes the refill line
 resp_data  out  512  refill line
 resp_err  out  1  refill aborted by timeout, valid with resp_valid
 read_L2_MEM  out  1  memory line read command
 write_L2_MEM  out  1  memory line write command
 tag_L2_MEM  out  TNUM  read tag
 index_L2_MEM  out  INUM  line index, shared by read and write
 write_tag_L2_MEM  out  TNUM  write tag
 write_data_L2_MEM  out  512  write line
 ready_MEM_L2  in  1  one-cycle command-complete pulse
 read_data_MEM_L2  in  512  read line, valid when ready_MEM_L2=1

Function
REQ-005 The FSM SHALL have the states IDLE, WB, GAP, FILL, RESP, all registered outputs.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid&req_ready, and all req_* fields are latched on that cycle.
REQ-007 On acceptance, the FSM SHALL go IDLE->WB if req_dirty=1, else IDLE->FILL.
REQ-008 In WB, write_L2_MEM=1, write_tag_L2_MEM=latched victim tag, index_L2_MEM=latched index, and write_data_L2_MEM=latched victim data, all held constant until ready_MEM_L2 is sampled 1.
REQ-009 When ready_MEM_L2=1 in WB, the FSM SHALL go WB->GAP and deassert write_L2_MEM on the next cycle.
REQ-010 GAP SHALL last exactly one cycle with both commands 0 and then go to FILL.
REQ-011 In FILL, read_L2_MEM=1, tag_L2_MEM=latched req_tag, and index_L2_MEM=latched index, all held until ready_MEM_L2 is sampled 1.
REQ-012 When ready_MEM_L2=1 in FILL, the block SHALL capture read_data_MEM_L2 into resp_data, set resp_err=0, go to RESP, and deassert read_L2_MEM on the next cycle.
REQ-013 read_L2_MEM and write_L2_MEM SHALL never both be 1 in the same cycle.
REQ-014 In RESP, resp_valid=1 and resp_data/resp_err SHALL remain stable until resp_ready=1, then the FSM goes RESP->IDLE; a new request is accepted no earlier than the following cycle.
REQ-015 A 10-bit wait counter SHALL clear on entry to WB or FILL and increment each cycle in those states without ready_MEM_L2.
REQ-016 When the counter reaches TIMEOUT in WB or FILL, the block SHALL drop the command, go to RESP with resp_err=1 and resp_data=0, and skip any remaining FILL.
REQ-017 A ready_MEM_L2 pulse received in IDLE, GAP or RESP SHALL be ignored with no state or data change.
REQ-018 ready_MEM_L2 and the timeout in the same cycle SHALL resolve as ready (success).
REQ-019 Memory-side address fields outside WB/FILL SHALL hold their last value; write_data_L2_MEM is don't-care outside WB.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, req_ready=1, all other outputs 0, resp_data=0, counter=0, and latched fields=0, including in mid-WB or mid-FILL.
REQ-021 After rst deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-022 Clean miss: req_tag=0x000123, index=5, dirty=0; memory answers after 64 cycles with data pattern 0xA5.. -> read_L2_MEM high 64 cycles, resp_valid with that data, resp_err=0.
REQ-023 Dirty miss: victim_tag=0x3FFFFF, victim data incrementing words 0..15 -> write_L2_MEM with those values until ready, one GAP cycle, then read of req_tag; overlap of the two commands is never observed.
REQ-024 Back-pressure: resp_ready held 0 for 10 cycles -> resp_valid and resp_data stable 10 cycles, req_ready=0 throughout.
REQ-025 Timeout: memory never answers, TIMEOUT=1023 -> command drops after 1023 cycles, resp_valid=1, resp_err=1, resp_data=0.
REQ-026 Reset mid-FILL at wait count 20 -> the next cycle shows all commands 0 and req_ready=1; a new request then completes normally.
REQ-027 Spurious ready_MEM_L2 pulse in IDLE, and ready coincident with timeout -> the pulse in IDLE has no effect; the coincident case returns resp_err=0.
